uvmt_mio_cli_st_clknrst_mgr: RTL
================================

UVMT_MIO_CLI_ST_CLKNRST_MGR -- requirements
Module: uvmt_mio_cli_st_clknrst_mgr

Interface
REQ-001 Parameter NUM_CH, default 4: number of generated clock/reset channels (1..16).
REQ-002 Parameter DIV_W, default 8: width of each per-channel divide value.
REQ-003 Parameter HOLD_W, default 8: width of each per-channel reset-hold value and of the release counter.
REQ-004 Parameter ASSERT_CYCLES, default 4: cycles spent in ASSERT (>=1).
REQ-005 Port clk  input  1: single reference clock; all flops rising-edge.
REQ-006 Port reset_n  input  1: reset, asynchronous, active-low.
REQ-007 Port en  input  1: level enable; 1 starts sequencing, 0 returns to IDLE.
REQ-008 Port sw_reset_req  input  1: single-cycle request to re-run the reset sequence.
REQ-009 Port div_ratio  input  NUM_CH*DIV_W: channel i half-period in clk cycles, bits [i*DIV_W +: DIV_W].
REQ-010 Port rst_hold  input  NUM_CH*HOLD_W: channel i release delay, bits [i*HOLD_W +: HOLD_W].
REQ-011 Port ch_clk  output  NUM_CH: generated clocks, registered.
REQ-012 Port ch_reset  output  NUM_CH: active-high channel resets, registered.
REQ-013 Port ch_reset_n  output  NUM_CH: active-low channel resets; always the bitwise inverse of ch_reset.
REQ-014 Port ready  output  1: high only in RUN.
REQ-015 Port busy  output  1: high in ASSERT or RELEASE.

Function
REQ-016 The FSM SHALL have states IDLE, ASSERT, RELEASE, RUN.
REQ-017 IDLE->ASSERT on first edge with en=1; ASSERT->RELEASE after exactly ASSERT_CYCLES edges in ASSERT; RELEASE->RUN on the edge after the last channel releases; RUN->ASSERT on an edge with sw_reset_req=1.
REQ-018 en=0 at any edge SHALL move to IDLE, overriding all other transitions; en=0 and sw_reset_req=1 together -> IDLE.
REQ-019 sw_reset_req outside RUN SHALL be ignored; in ASSERT it does not extend the count.
REQ-020 In IDLE and ASSERT all ch_reset SHALL be 1.
REQ-021 On entry to RELEASE the release counter SHALL be 0, incrementing each RELEASE cycle and saturating at 2^HOLD_W-1.
REQ-022 Channel i SHALL deassert at the first edge where counter >= rst_hold[i], i.e. rst_hold[i]+1 edges after RELEASE entry; once released it stays released until ASSERT or IDLE.
REQ-023 Each channel SHALL have a DIV_W counter; ch_clk[i] toggles when the counter reaches D-1, then the counter clears; D=div_ratio[i], D=0 treated as 1; period is 2*D clk cycles.
REQ-024 div_ratio[i] SHALL be sampled only at a toggle of ch_clk[i]; mid-half-period changes take effect from the next half-period (no runt pulses).
REQ-025 ch_clk SHALL run in ASSERT, RELEASE, RUN; on the edge entering IDLE all ch_clk and divider counters SHALL clear to 0.
REQ-026 ready and busy SHALL be registered, changing on the same edge as the state change.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, ch_clk=0, ch_reset=all 1, ch_reset_n=all 0, ready=0, busy=0, all counters 0.
REQ-028 reset_n deassertion mid-sequence SHALL restart from IDLE; with en=1 held, ASSERT is entered on the first edge after release.

Configuration
REQ-029 Macro UVMT_MIO_CLI_ST_CLKNRST_MGR_CLK_GATE_EN: when defined, ch_clk[i] SHALL be held 0 and its divider cleared while ch_reset[i]=1, starting at count 0 on the edge after release; when undefined, clocks run through ASSERT/RELEASE per REQ-025.

Verification
REQ-030 NUM_CH=4, ASSERT_CYCLES=4, rst_hold={0,3,7,2}, en rises -> busy for 4 ASSERT cycles; channels release 1,3,4,8 edges after RELEASE entry; ready rises 9 edges after RELEASE entry.
REQ-031 div_ratio ch0=1, ch1=3, ch2=0 -> periods 2, 6, 2 clk cycles; ch1 changed 3->5 mid-half-period -> current half-period 3 cycles, then 5-cycle half-periods, no shorter pulse.
REQ-032 In RUN pulse sw_reset_req one cycle -> next edge: ready=0, busy=1, all ch_reset=1; sequence of REQ-030 repeats identically.
REQ-033 en dropped during RELEASE with 2 channels released -> next edge IDLE: all ch_reset=1, ch_clk=0, busy=0; en=0 and sw_reset_req=1 in RUN -> IDLE.
REQ-034 reset_n pulsed low asynchronously mid-RUN -> outputs at REQ-027 values without waiting for clk; en=1 held -> ASSERT on first edge after release.
REQ-035 With CLK_GATE_EN, rst_hold ch3=5, div_ratio ch3=2 -> ch_clk[3] low throughout ASSERT/RELEASE until release, first rising edge of ch_clk[3] 2 edges after release.

Source files
------------

// File: rtl/uvmt_mio_cli_st_clknrst_mgr.sv
// Clock/reset manager: per-channel divided clocks plus an IDLE/ASSERT/RELEASE/RUN reset sequencer.
// Optional UVMT_MIO_CLI_ST_CLKNRST_MGR_CLK_GATE_EN holds each channel clock low while its reset is set.
module uvmt_mio_cli_st_clknrst_mgr #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned HOLD_W        = 8,
  parameter int unsigned ASSERT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     sw_reset_req,
  input  logic [NUM_CH*DIV_W-1:0]  div_ratio,
  input  logic [NUM_CH*HOLD_W-1:0] rst_hold,
  output logic [NUM_CH-1:0]        ch_clk,
  output logic [NUM_CH-1:0]        ch_reset,
  output logic [NUM_CH-1:0]        ch_reset_n,
  output logic                     ready,
  output logic                     busy
);

  localparam int unsigned AcntW = (ASSERT_CYCLES > 1) ? $clog2(ASSERT_CYCLES) : 1;
  localparam logic [AcntW-1:0] AcntLast = AcntW'(ASSERT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAssert, StRelease, StRun} state_e;

  state_e              state_q, state_d;
  logic [AcntW-1:0]    acnt_q, acnt_d;
  logic [HOLD_W-1:0]   rcnt_q, rcnt_d;
  logic [NUM_CH-1:0]   ch_reset_q, ch_reset_d;
  logic                ready_q, busy_q;

  always_comb begin
    state_d    = state_q;
    acnt_d     = acnt_q;
    rcnt_d     = rcnt_q;
    ch_reset_d = ch_reset_q;
    case (state_q)
      StIdle: begin
        state_d = StAssert;
        acnt_d  = '0;
      end
      StAssert: begin
        if (acnt_q == AcntLast) begin
          state_d = StRelease;
          rcnt_d  = '0;
        end else begin
          acnt_d = acnt_q + AcntW'(1);
        end
      end
      StRelease: begin
        // Leave one edge after the final channel has dropped its reset.
        if (ch_reset_q == '0) begin
          state_d = StRun;
        end else begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rcnt_q >= rst_hold[i*HOLD_W +: HOLD_W]) ch_reset_d[i] = 1'b0;
          end
          if (rcnt_q != '1) rcnt_d = rcnt_q + HOLD_W'(1);
        end
      end
      StRun: begin
        if (sw_reset_req) begin
          state_d    = StAssert;
          acnt_d     = '0;
          ch_reset_d = '1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en) begin
      state_d    = StIdle;
      acnt_d     = '0;
      rcnt_d     = '0;
      ch_reset_d = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      acnt_q     <= '0;
      rcnt_q     <= '0;
      ch_reset_q <= '1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acnt_q     <= acnt_d;
      rcnt_q     <= rcnt_d;
      ch_reset_q <= ch_reset_d;
      ready_q    <= (state_d == StRun);
      busy_q     <= (state_d == StAssert) || (state_d == StRelease);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_eff;
    logic             clk_q;
    logic             stop;

    assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;

`ifdef UVMT_MIO_CLI_ST_CLKNRST_MGR_CLK_GATE_EN
    // Gating on both current and next reset keeps the clock low from the very edge reset rises.
    assign stop = (state_q == StIdle) || (state_d == StIdle) || ch_reset_q[g] || ch_reset_d[g];
`else
    assign stop = (state_q == StIdle) || (state_d == StIdle);
`endif

    // The ratio is captured only while stopped or at a toggle, so half-periods never shorten.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        div_q <= '0;
        clk_q <= 1'b0;
      end else if (stop) begin
        cnt_q <= '0;
        div_q <= div_ratio[g*DIV_W +: DIV_W];
        clk_q <= 1'b0;
      end else if (cnt_q == (div_eff - DIV_W'(1))) begin
        cnt_q <= '0;
        div_q <= div_ratio[g*DIV_W +: DIV_W];
        clk_q <= ~clk_q;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end

    assign ch_clk[g] = clk_q;
  end

  assign ch_reset   = ch_reset_q;
  assign ch_reset_n = ~ch_reset_q;
  assign ready      = ready_q;
  assign busy       = busy_q;

endmodule
